mem_selftest: RTL and testbench
===============================

MEM_SELFTEST -- requirements
Module: mem_selftest

Interface
REQ-001 SHALL have parameter ADDR_W, 24, address width.
REQ-002 SHALL have parameter DATA_W, 8, data width.
REQ-003 SHALL have parameter WAIT_CYCLES, 50000, power-up settle delay before the first memory access of each run.
REQ-004 SHALL have parameter STOP_ON_ERROR, 1, abort run on first mismatch when 1.
REQ-005 SHALL have port clkSys  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_start  in  1  start pulse.
REQ-008 SHALL have port i_mode  in  2  pattern mode.
REQ-009 SHALL have port i_pattern  in  DATA_W  fixed pattern.
REQ-010 SHALL have port i_firstAddr  in  ADDR_W  first address tested.
REQ-011 SHALL have port i_lastAddr  in  ADDR_W  last address tested, inclusive.
REQ-012 SHALL have port o_cs  out  1  active-low request strobe to memCtrl.
REQ-013 SHALL have port o_write  out  1  1 = write, 0 = read.
REQ-014 SHALL have port o_address  out  ADDR_W  request address.
REQ-015 SHALL have port o_dataToWrite  out  DATA_W  write data.
REQ-016 SHALL have port i_dataRead  in  DATA_W  read data from memCtrl.
REQ-017 SHALL have port i_busy  in  1  memCtrl busy.
REQ-018 SHALL have port i_dataReady  in  1  memCtrl read data valid.
REQ-019 SHALL have port o_busy  out  1  run in progress.
REQ-020 SHALL have port o_done  out  1  run finished, held until next start or reset.
REQ-021 SHALL have port o_fail  out  1  run failed, valid while o_done.
REQ-022 SHALL have port o_errCount  out  16  mismatch count, saturating at 16'hFFFF.
REQ-023 SHALL have port o_failAddr  out  ADDR_W  address of first mismatch.
REQ-024 SHALL have port o_failData  out  DATA_W  data read at first mismatch.

Function
REQ-025 SHALL implement states IDLE, DELAY, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE; o_busy=1 in all states except IDLE and DONE.
REQ-026 SHALL, on i_start in IDLE or DONE, register i_mode/i_pattern/i_firstAddr/i_lastAddr, clear o_done/o_fail/o_errCount/o_failAddr/o_failData, set address counter to first, enter DELAY; i_start while o_busy=1 SHALL be ignored.
REQ-027 SHALL, if lastAddr < firstAddr at start, skip DELAY and go to DONE next cycle with o_fail=1, o_errCount=0, o_failAddr=firstAddr, no memory access.
REQ-028 SHALL stay in DELAY exactly WAIT_CYCLES+1 cycles, then enter WR_REQ.
REQ-029 SHALL compute pattern(addr): mode0 = pattern; mode1 = addr[DATA_W-1:0]; mode2 = 1 << (addr mod DATA_W); mode3 = ~addr[DATA_W-1:0].
REQ-030 SHALL, in WR_REQ/RD_REQ, wait while i_busy=1; with i_busy=0 drive o_cs=0 for exactly one cycle with o_write, o_address and o_dataToWrite (=pattern(addr) on write) valid that cycle, then enter WR_WAIT/RD_WAIT; o_cs=1 in all other cycles.
REQ-031 SHALL leave WR_WAIT on the first cycle with i_busy=0 that is not the cycle immediately after the o_cs pulse; if addr==last, reload addr=first and go to RD_REQ, else addr+1 and go to WR_REQ (all writes precede all reads).
REQ-032 SHALL, in RD_WAIT, on i_dataReady=1 and i_busy=0 capture i_dataRead and enter CHECK; no timeout.
REQ-033 SHALL, in CHECK (one cycle), on mismatch increment o_errCount (saturating) and, if first mismatch, load o_failAddr/o_failData.
REQ-034 SHALL leave CHECK to DONE if (mismatch and STOP_ON_ERROR=1) or addr==last, else addr+1 to RD_REQ; counter SHALL never wrap (lastAddr all-ones terminates normally).
REQ-035 SHALL, on entering DONE, set o_done=1 and o_fail=(o_errCount!=0 including the current mismatch) and hold until next start.

Reset
REQ-036 SHALL, on reset asserted at any time including mid-run, immediately force IDLE, o_cs=1, o_write=0, o_address=0, o_dataToWrite=0, o_busy=0, o_done=0, o_fail=0, o_errCount=0, o_failAddr=0, o_failData=0, DELAY counter 0; no request is issued until a new i_start after reset release.

Verification
REQ-037 WAIT_CYCLES=4, mode0 pattern 8'hAA, range 0x10..0x13, ideal memory model -> four writes of 8'hAA then four reads, o_done=1, o_fail=0, o_errCount=0, first o_cs low 5 cycles after DELAY entry.
REQ-038 mode1, range 0x100..0x1FF, memory stuck-at bit0=0 at addr 0x105, STOP_ON_ERROR=0 -> o_errCount=1, o_failAddr=0x105, o_failData=0x04, o_fail=1, all 256 reads performed.
REQ-039 STOP_ON_ERROR=1, mode2, every read returns 0 -> DONE after first read, o_errCount=1, o_failAddr=firstAddr, no further o_cs pulses.
REQ-040 firstAddr=0x20, lastAddr=0x1F -> DONE one cycle after start, o_fail=1, o_errCount=0, o_cs never low.
REQ-041 range 0xFFFFFE..0xFFFFFF with i_busy held high 10 cycles after each request -> exactly one o_cs pulse per access, no wrap to 0, o_done=1.
REQ-042 reset asserted during RD_WAIT, i_start during run ignored -> all outputs at reset values same cycle, restart after i_start completes normally.

Source files
------------

// File: rtl/mem_selftest.sv
`default_nettype none
// ============================================================================
//  Module      : mem_selftest
//  Description : Memory self-test sequencer. Writes a pattern over an
//                inclusive address range through a memCtrl request port,
//                reads the range back, and reports mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_selftest #(
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 8,
    parameter int WAIT_CYCLES   = 50000,
    parameter int STOP_ON_ERROR = 1
) (
    input  logic              clkSys,
    input  logic              reset,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic [ADDR_W-1:0] i_firstAddr,
    input  logic [ADDR_W-1:0] i_lastAddr,
    output logic              o_cs,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_dataToWrite,
    input  logic [DATA_W-1:0] i_dataRead,
    input  logic              i_busy,
    input  logic              i_dataReady,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fail,
    output logic [15:0]       o_errCount,
    output logic [ADDR_W-1:0] o_failAddr,
    output logic [DATA_W-1:0] o_failData
);

    // Counter wide enough to hold WAIT_CYCLES (also valid when it is 0).
    localparam int                c_CNT_W    = $clog2(WAIT_CYCLES + 2);
    localparam logic [c_CNT_W-1:0] c_WAIT    = c_CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] c_DW_A     = ADDR_W'(DATA_W);
    localparam logic [DATA_W-1:0] c_ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       c_ERR_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DELAY   = 3'd1,
        S_WR_REQ  = 3'd2,
        S_WR_WAIT = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_CHECK   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_pattern;
    logic [ADDR_W-1:0]   r_first;
    logic [ADDR_W-1:0]   r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_CNT_W-1:0]  r_delay;
    logic                r_after_req;   // cycle right after an o_cs pulse
    logic [DATA_W-1:0]   r_rdata;
    logic [15:0]         r_err;
    logic                r_fail;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;

    logic                w_start;
    logic                w_bad_range;
    logic                w_req;
    logic                w_at_last;
    logic                w_mismatch;
    logic [DATA_W-1:0]   w_expected;

    function automatic logic [DATA_W-1:0] f_pattern(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] pat,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] v;
        case (mode)
            2'd0:    v = pat;
            2'd1:    v = addr[DATA_W-1:0];
            2'd2:    v = c_ONE << (addr % c_DW_A);
            default: v = ~addr[DATA_W-1:0];
        endcase
        return v;
    endfunction

    assign w_start     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_bad_range = (i_lastAddr < i_firstAddr);
    assign w_req       = ((r_state == S_WR_REQ) || (r_state == S_RD_REQ)) && !i_busy;
    assign w_at_last   = (r_addr == r_last);
    assign w_expected  = f_pattern(r_mode, r_pattern, r_addr);
    assign w_mismatch  = (r_rdata != w_expected);

    assign o_cs          = !w_req;
    assign o_write       = (r_state == S_WR_REQ);
    assign o_address     = r_addr;
    assign o_dataToWrite = (r_state == S_WR_REQ) ? w_expected : '0;
    assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done        = (r_state == S_DONE);
    assign o_fail        = r_fail;
    assign o_errCount    = r_err;
    assign o_failAddr    = r_fail_addr;
    assign o_failData    = r_fail_data;

    // State register.
    always_ff @(posedge clkSys or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic; addresses never wrap because the last address exits.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start) w_next_state = w_bad_range ? S_DONE : S_DELAY;
            S_DELAY:        if (r_delay == c_WAIT) w_next_state = S_WR_REQ;
            S_WR_REQ:       if (!i_busy) w_next_state = S_WR_WAIT;
            S_WR_WAIT:      if (!r_after_req && !i_busy)
                                w_next_state = w_at_last ? S_RD_REQ : S_WR_REQ;
            S_RD_REQ:       if (!i_busy) w_next_state = S_RD_WAIT;
            S_RD_WAIT:      if (i_dataReady && !i_busy) w_next_state = S_CHECK;
            S_CHECK:        if ((w_mismatch && (STOP_ON_ERROR != 0)) || w_at_last)
                                w_next_state = S_DONE;
                            else
                                w_next_state = S_RD_REQ;
            default:        w_next_state = S_IDLE;
        endcase
    end

    // Run configuration, address/delay counters and result registers.
    always_ff @(posedge clkSys or posedge reset) begin
        if (reset) begin
            r_mode      <= '0;
            r_pattern   <= '0;
            r_first     <= '0;
            r_last      <= '0;
            r_addr      <= '0;
            r_delay     <= '0;
            r_after_req <= 1'b0;
            r_rdata     <= '0;
            r_err       <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            r_after_req <= w_req;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_mode      <= i_mode;
                        r_pattern   <= i_pattern;
                        r_first     <= i_firstAddr;
                        r_last      <= i_lastAddr;
                        r_addr      <= i_firstAddr;
                        r_delay     <= '0;
                        r_err       <= '0;
                        r_fail_data <= '0;
                        // An empty range is reported as a failure at its first address.
                        r_fail      <= w_bad_range;
                        r_fail_addr <= w_bad_range ? i_firstAddr : '0;
                    end
                end
                S_DELAY: begin
                    if (r_delay != c_WAIT) r_delay <= r_delay + 1'b1;
                end
                S_WR_WAIT: begin
                    if (!r_after_req && !i_busy)
                        r_addr <= w_at_last ? r_first : r_addr + 1'b1;
                end
                S_RD_WAIT: begin
                    if (i_dataReady && !i_busy) r_rdata <= i_dataRead;
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err != c_ERR_MAX) r_err <= r_err + 16'd1;
                        if (r_err == '0) begin
                            r_fail_addr <= r_addr;
                            r_fail_data <= r_rdata;
                        end
                    end
                    if (w_next_state == S_DONE) r_fail <= (r_err != '0) || w_mismatch;
                    else                        r_addr <= r_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_selftest.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_selftest
//  Description : Self-checking bench for mem_selftest with a behavioural
//                memCtrl model and a request scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_selftest;

    localparam int AW = 24;
    localparam int DW = 8;
    localparam int WC = 4;

    logic          clkSys = 1'b0;
    logic          reset;
    logic          startA, startB;
    logic [1:0]    mode;
    logic [DW-1:0] pattern;
    logic [AW-1:0] firstAddr, lastAddr;
    logic [DW-1:0] dataRead;
    logic          memBusy;
    logic          dataReady = 1'b0;

    logic          a_cs, a_write, a_busy, a_done, a_fail;
    logic [AW-1:0] a_address, a_faddr;
    logic [DW-1:0] a_dtw, a_fdata;
    logic [15:0]   a_err;
    logic          b_cs, b_write, b_busy, b_done, b_fail;
    logic [AW-1:0] b_address, b_faddr;
    logic [DW-1:0] b_dtw, b_fdata;
    logic [15:0]   b_err;

    int checks = 0;
    int errors = 0;

    always #5 clkSys = ~clkSys;

    mem_selftest #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .STOP_ON_ERROR(0)) dut_a (
        .clkSys(clkSys), .reset(reset), .i_start(startA), .i_mode(mode), .i_pattern(pattern),
        .i_firstAddr(firstAddr), .i_lastAddr(lastAddr), .o_cs(a_cs), .o_write(a_write),
        .o_address(a_address), .o_dataToWrite(a_dtw), .i_dataRead(dataRead), .i_busy(memBusy),
        .i_dataReady(dataReady), .o_busy(a_busy), .o_done(a_done), .o_fail(a_fail),
        .o_errCount(a_err), .o_failAddr(a_faddr), .o_failData(a_fdata));

    mem_selftest #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .STOP_ON_ERROR(1)) dut_b (
        .clkSys(clkSys), .reset(reset), .i_start(startB), .i_mode(mode), .i_pattern(pattern),
        .i_firstAddr(firstAddr), .i_lastAddr(lastAddr), .o_cs(b_cs), .o_write(b_write),
        .o_address(b_address), .o_dataToWrite(b_dtw), .i_dataRead(dataRead), .i_busy(memBusy),
        .i_dataReady(dataReady), .o_busy(b_busy), .o_done(b_done), .o_fail(b_fail),
        .o_errCount(b_err), .o_failAddr(b_faddr), .o_failData(b_fdata));

    // The memory model serves whichever instance is selected.
    logic          sel;
    logic          m_cs, m_write, m_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    assign m_cs    = sel ? b_cs      : a_cs;
    assign m_write = sel ? b_write   : a_write;
    assign m_addr  = sel ? b_address : a_address;
    assign m_data  = sel ? b_dtw     : a_dtw;
    assign m_done  = sel ? b_done    : a_done;

    // Behavioural memCtrl: busy for busy_len cycles after each request,
    // read data presented one cycle after busy falls.
    logic [DW-1:0] mem [0:1023];
    int            busy_len   = 0;
    int            busy_cnt   = 0;
    logic          pending    = 1'b0;
    logic          stuck_en   = 1'b0;
    logic          zero_reads = 1'b0;
    logic [AW-1:0] stuck_addr = '0;
    logic [AW-1:0] rd_addr    = '0;
    assign memBusy = (busy_cnt != 0);

    always @(posedge clkSys) begin
        dataReady <= 1'b0;
        if (!m_cs) begin
            if (m_write) mem[m_addr[9:0]] <= m_data;
            else begin
                pending <= 1'b1;
                rd_addr <= m_addr;
            end
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (pending) begin
            pending   <= 1'b0;
            dataReady <= 1'b1;
            if (zero_reads)                           dataRead <= '0;
            else if (stuck_en && rd_addr == stuck_addr) dataRead <= mem[rd_addr[9:0]] & 8'hFE;
            else                                      dataRead <= mem[rd_addr[9:0]];
        end
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;
    req_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every request pulse must match the next expected access.
    always @(negedge clkSys) begin
        req_t e;
        if (!m_cs) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_req observed_addr=%h expected=none", m_addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("req_kind_addr", {7'd0, m_write, m_addr}, {7'd0, e.wr, e.addr});
                if (e.wr) chk("req_wdata", {24'd0, m_data}, {24'd0, e.data});
            end
        end
    end

    task automatic run_start(input bit useB, input logic [1:0] md, input logic [DW-1:0] pat,
                             input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(negedge clkSys);
        mode = md; pattern = pat; firstAddr = f; lastAddr = l;
        if (useB) startB = 1'b1; else startA = 1'b1;
        @(negedge clkSys);
        startA = 1'b0; startB = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (!m_done && n < max) begin
            @(negedge clkSys);
            n++;
        end
        chk({tag, "_done"}, {31'd0, m_done}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"}, {31'd0, a_cs}, 32'd1);
        chk({tag, "_busy_done_fail"}, {29'd0, a_busy, a_done, a_fail}, 32'd0);
        chk({tag, "_wr_addr"}, {7'd0, a_write, a_address}, 32'd0);
        chk({tag, "_wdata_fdata"}, {16'd0, a_dtw, a_fdata}, 32'd0);
        chk({tag, "_err"}, {16'd0, a_err}, 32'd0);
        chk({tag, "_faddr"}, {8'd0, a_faddr}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; startA = 1'b0; startB = 1'b0; sel = 1'b0;
        mode = '0; pattern = '0; firstAddr = '0; lastAddr = '0;
        repeat (3) @(negedge clkSys);
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clkSys);

        // Fixed pattern 0xAA over 0x10..0x13, ideal memory.
        for (int a = 'h10; a <= 'h13; a++) push(1'b1, AW'(a), 8'hAA);
        for (int a = 'h10; a <= 'h13; a++) push(1'b0, AW'(a), 8'h00);
        run_start(1'b0, 2'd0, 8'hAA, 24'h10, 24'h13);
        n = 0;
        while (m_cs && n < 50) begin
            @(negedge clkSys);
            n++;
        end
        chk("t1_first_cs_latency", n, 32'd5);
        wait_done(300, "t1");
        chk("t1_fail_err", {15'd0, a_fail, a_err}, 32'd0);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // Address pattern over 0x100..0x1FF, bit0 stuck low at 0x105, no abort.
        stuck_en = 1'b1; stuck_addr = 24'h105;
        for (int a = 'h100; a <= 'h1FF; a++) push(1'b1, AW'(a), DW'(a));
        for (int a = 'h100; a <= 'h1FF; a++) push(1'b0, AW'(a), 8'h00);
        run_start(1'b0, 2'd1, 8'h00, 24'h100, 24'h1FF);
        wait_done(6000, "t2");
        chk("t2_err", {16'd0, a_err}, 32'd1);
        chk("t2_faddr", {8'd0, a_faddr}, 32'h105);
        chk("t2_fdata", {24'd0, a_fdata}, 32'h04);
        chk("t2_fail", {31'd0, a_fail}, 32'd1);
        chk("t2_all_reads_done", exp_q.size(), 32'd0);
        stuck_en = 1'b0;

        // Walking one, every read returns 0, abort on first mismatch.
        sel = 1'b1; zero_reads = 1'b1;
        push(1'b1, 24'h30, 8'h01); push(1'b1, 24'h31, 8'h02);
        push(1'b1, 24'h32, 8'h04); push(1'b1, 24'h33, 8'h08);
        push(1'b0, 24'h30, 8'h00);
        run_start(1'b1, 2'd2, 8'h00, 24'h30, 24'h33);
        wait_done(300, "t3");
        chk("t3_err", {16'd0, b_err}, 32'd1);
        chk("t3_faddr", {8'd0, b_faddr}, 32'h30);
        chk("t3_fdata_fail", {23'd0, b_fdata, b_fail}, 32'd1);
        repeat (20) @(negedge clkSys);
        chk("t3_queue_empty", exp_q.size(), 32'd0);
        zero_reads = 1'b0; sel = 1'b0;

        // Empty range: immediate failure, no access.
        run_start(1'b0, 2'd0, 8'h00, 24'h20, 24'h1F);
        chk("t4_done_fail", {30'd0, a_done, a_fail}, 32'd3);
        chk("t4_err", {16'd0, a_err}, 32'd0);
        chk("t4_faddr", {8'd0, a_faddr}, 32'h20);
        repeat (10) @(negedge clkSys);

        // Top of the address space with a slow memory, inverted-address pattern.
        busy_len = 10;
        push(1'b1, 24'hFFFFFE, 8'h01); push(1'b1, 24'hFFFFFF, 8'h00);
        push(1'b0, 24'hFFFFFE, 8'h00); push(1'b0, 24'hFFFFFF, 8'h00);
        run_start(1'b0, 2'd3, 8'h00, 24'hFFFFFE, 24'hFFFFFF);
        wait_done(500, "t5");
        chk("t5_fail_err", {15'd0, a_fail, a_err}, 32'd0);
        chk("t5_no_wrap_addr", {8'd0, a_address}, 32'hFFFFFF);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

        // Reset during a read; a start pulse mid-run must be ignored.
        push(1'b1, 24'h40, 8'h5A); push(1'b1, 24'h41, 8'h5A); push(1'b0, 24'h40, 8'h00);
        run_start(1'b0, 2'd0, 8'h5A, 24'h40, 24'h41);
        firstAddr = 24'h50; lastAddr = 24'h50; startA = 1'b1;
        @(negedge clkSys);
        startA = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clkSys);
            n++;
        end
        chk("t6_read_issued", exp_q.size(), 32'd0);
        repeat (2) @(negedge clkSys);
        chk("t6_busy_mid_read", {31'd0, a_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("t6_async_rst");
        @(negedge clkSys);
        reset = 1'b0;
        repeat (15) @(negedge clkSys);
        busy_len = 0;
        push(1'b1, 24'h40, 8'h5A); push(1'b1, 24'h41, 8'h5A);
        push(1'b0, 24'h40, 8'h00); push(1'b0, 24'h41, 8'h00);
        run_start(1'b0, 2'd0, 8'h5A, 24'h40, 24'h41);
        wait_done(300, "t6_restart");
        chk("t6_restart_fail_err", {15'd0, a_fail, a_err}, 32'd0);
        chk("t6_restart_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
